frame_buffer_scanout: RTL and testbench
=======================================

FRAME_BUFFER_SCANOUT -- requirements
Module: frame_buffer_scanout

Interface
REQ-001 Parameter: width, 4, x-coordinate bit width; screen is 2^width pixels wide.
REQ-002 Parameter: height, 3, y-coordinate bit width; screen is 2^height pixels tall.
REQ-003 Parameter: color_bits, 8, bits per colour channel.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 wr_valid  in  1  pixel write request from the pixel-combining stage.
REQ-007 wr_ready  out  1  write accepted on the edge where wr_valid && wr_ready.
REQ-008 wr_x  in  width  and  wr_y  in  height  pixel coordinate.
REQ-009 wr_rgb  in  3*color_bits  colour as {r,g,b}.
REQ-010 clear_req  in  1  one-cycle request to zero the whole buffer.
REQ-011 frame_start  in  1  one-cycle request to scan the buffer out.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 scan_valid  out  1  and  scan_ready  in  1  scanout handshake.
REQ-014 scan_x  out  width,  scan_y  out  height,  scan_rgb  out  3*color_bits  scanned pixel.
REQ-015 scan_last  out  1  high with the final pixel of a frame.
REQ-016 frame_count  out  8  count of completed scanouts.

Function
REQ-017 FSM states: IDLE, CLEAR, SCAN; storage holds 2^(width+height) words, address = {y,x}.
REQ-018 wr_ready is high only in IDLE; an accepted write stores wr_rgb at {wr_y,wr_x} on that edge.
REQ-019 In IDLE, clear_req moves to CLEAR; frame_start moves to SCAN; if both are high in the same cycle, CLEAR wins and frame_start is dropped.
REQ-020 A write accepted in the same cycle as clear_req or frame_start completes and is visible to the following clear or scan.
REQ-021 clear_req and frame_start outside IDLE are ignored, not queued.
REQ-022 CLEAR writes zero to one address per cycle, from 0 to 2^(width+height)-1, then returns to IDLE; the clear therefore lasts exactly 2^(width+height) cycles.
REQ-023 SCAN: frame_start sampled on edge N; scan_valid is high from edge N+1 with pixel (0,0); order is raster, with x fastest and x wrapping to 0 while y increments.
REQ-024 Each pixel advances only on scan_valid && scan_ready; while scan_ready is low, scan_x, scan_y, scan_rgb and scan_last hold stable.
REQ-025 With scan_ready held high, one pixel transfers per cycle with no bubbles.
REQ-026 scan_last is high only at x=2^width-1, y=2^height-1; after that handshake, the next cycle has scan_valid=0 and state IDLE, and frame_count increments.
REQ-027 frame_count wraps from 255 to 0.
REQ-028 scan_valid is low outside SCAN; scan_x, scan_y and scan_rgb are don't-care when scan_valid is low.

Reset
REQ-029 Reset forces IDLE and sets busy=0, scan_valid=0, scan_last=0, scan_x=0, scan_y=0, scan_rgb=0, frame_count=0; wr_ready is 1 from the first cycle after reset.
REQ-030 Reset mid-CLEAR or mid-SCAN aborts the operation, and frame_count does not increment for the aborted scan.
REQ-031 Storage contents are not reset; they are undefined until written or cleared.

Configuration
REQ-032 Macro FRAME_BUFFER_CLEAR_EN: when defined, CLEAR state and the clear_req function exist as specified above.
REQ-033 Without FRAME_BUFFER_CLEAR_EN: the clear_req port remains but is ignored, the CLEAR state and its address counter are not built, and clear_req with frame_start starts a scan.

Structure
REQ-034 Shared package fb_pkg holds the FSM state enum, the default COLOR_BITS constant, and an rgb_t typedef of three channels.
REQ-035 Storage is a single sub-module fb_ram: single-port, synchronous write, registered read with 1-cycle latency; single-port suffices because writes, clear and scan are mutually exclusive.

Verification
REQ-036 Write (3,2)=0xFF0000 and (15,7)=0x00FF00, then frame_start with scan_ready=1 -> 128 pixels in raster order, with pixel 35 = 0xFF0000, pixel 127 = 0x00FF00 and scan_last, then frame_count=1.
REQ-037 Issue clear_req, then frame_start after busy falls -> busy is high for exactly 128 cycles, and the scan returns all 128 pixels as 0.
REQ-038 During a scan, drop scan_ready for 3 cycles at pixel 10 -> outputs hold pixel 10 unchanged; no pixel is lost or repeated.
REQ-039 clear_req and frame_start in the same cycle -> clear runs; no scan_valid until a new frame_start is issued.
REQ-040 Assert reset at pixel 50 of a scan -> next cycle scan_valid=0, busy=0, frame_count unchanged (0 after reset), wr_ready=1.
REQ-041 Run 256 complete scans -> frame_count wraps to 0; additionally, wr_valid during SCAN stays unaccepted (wr_ready=0) until the scan completes.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the frame buffer scanout block.
package fb_pkg;

  localparam int COLOR_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SCAN  = 2'd2
  } state_t;

  typedef struct packed {
    logic [COLOR_BITS-1:0] r;
    logic [COLOR_BITS-1:0] g;
    logic [COLOR_BITS-1:0] b;
  } rgb_t;

endpackage

// File: rtl/fb_ram.sv
// Single-port pixel storage: synchronous write, registered read (1-cycle latency).
module fb_ram #(
  parameter int addr_bits = 7,
  parameter int data_bits = 24
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [addr_bits-1:0] addr,
  input  logic [data_bits-1:0] wdata,
  output logic [data_bits-1:0] rdata
);

  logic [data_bits-1:0] mem [2**addr_bits];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/frame_buffer_scanout.sv
// Frame buffer with pixel write port, optional whole-buffer clear and raster scanout.
// Define FRAME_BUFFER_CLEAR_EN to build the CLEAR state and honour clear_req.
module frame_buffer_scanout
  import fb_pkg::*;
#(
  parameter int width      = 4,
  parameter int height     = 3,
  parameter int color_bits = COLOR_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [width-1:0]        wr_x,
  input  logic [height-1:0]       wr_y,
  input  logic [3*color_bits-1:0] wr_rgb,
  input  logic                    clear_req,
  input  logic                    frame_start,
  output logic                    busy,
  output logic                    scan_valid,
  input  logic                    scan_ready,
  output logic [width-1:0]        scan_x,
  output logic [height-1:0]       scan_y,
  output logic [3*color_bits-1:0] scan_rgb,
  output logic                    scan_last,
  output logic [7:0]              frame_count,
  output state_t                  debug_state
);

  localparam int addr_bits = width + height;
  localparam int data_bits = 3 * color_bits;
  localparam logic [addr_bits-1:0] last_addr = '1;

  // Handshakes: a transfer happens on the rising edge where valid && ready;
  // ready never depends on valid, and the producer holds its payload while stalled.

  state_t state;
  state_t state_next;

  logic [addr_bits-1:0] pix;
  logic [addr_bits-1:0] pix_next;
  logic [addr_bits-1:0] ram_addr;
  logic [data_bits-1:0] ram_wdata;
  logic [data_bits-1:0] ram_rdata;
  logic [data_bits-1:0] pix0_shadow;
  logic                 ram_we;
  logic                 wr_fire;
  logic                 scan_fire;
  logic                 clearing;
  logic                 clear_go;
  logic [addr_bits-1:0] clr_addr;

`ifdef FRAME_BUFFER_CLEAR_EN
  assign clearing = (state == ST_CLEAR);
  assign clear_go = clear_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_addr <= '0;
    end else if (clearing) begin
      clr_addr <= clr_addr + addr_bits'(1);
    end
  end
`else
  logic unused_clear_req;
  assign unused_clear_req = clear_req;
  assign clearing         = 1'b0;
  assign clear_go         = 1'b0;
  assign clr_addr         = '0;
`endif

  assign wr_ready    = (state == ST_IDLE);
  assign wr_fire     = wr_valid && wr_ready;
  assign busy        = (state != ST_IDLE);
  assign scan_valid  = (state == ST_SCAN);
  assign scan_fire   = scan_valid && scan_ready;
  assign debug_state = state;
  assign pix_next    = scan_fire ? pix + addr_bits'(1) : pix;

  assign scan_x    = pix[width-1:0];
  assign scan_y    = pix[addr_bits-1:width];
  assign scan_last = scan_valid && (pix == last_addr);

  // Pixel 0 must be on the bus the cycle after frame_start, but on that edge the
  // single port may be busy with a write, so address 0 is mirrored in a register.
  assign scan_rgb = !scan_valid   ? '0 :
                    (pix == '0)   ? pix0_shadow : ram_rdata;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (clear_go) begin
          state_next = ST_CLEAR;
        end else if (frame_start) begin
          state_next = ST_SCAN;
        end
      end
      ST_CLEAR: begin
        if (clr_addr == last_addr) begin
          state_next = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (scan_fire && (pix == last_addr)) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // During a scan the RAM reads the pixel that will be presented after this edge,
  // so a stall simply re-reads the same address.
  always_comb begin
    ram_we    = wr_fire || clearing;
    ram_wdata = clearing ? '0 : wr_rgb;
    ram_addr  = {wr_y, wr_x};
    if (clearing) begin
      ram_addr = clr_addr;
    end else if (scan_valid) begin
      ram_addr = pix_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pix         <= '0;
      frame_count <= '0;
    end else begin
      state <= state_next;
      pix   <= pix_next;
      if (scan_fire && (pix == last_addr)) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we && (ram_addr == '0)) begin
      pix0_shadow <= ram_wdata;
    end
  end

  fb_ram #(
    .addr_bits (addr_bits),
    .data_bits (data_bits)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_frame_buffer_scanout.sv
// Self-checking bench for frame_buffer_scanout: table vectors, corner sequences and
// random writes/backpressure checked against a pixel-array model.
module tb_frame_buffer_scanout;
  import fb_pkg::*;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int CB   = 8;
  localparam int ADDR = W + H;
  localparam int NPIX = 1 << ADDR;
  localparam int DW   = 3 * CB;
  localparam int SBW  = ADDR + DW + 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          wr_valid;
  logic          wr_ready;
  logic [W-1:0]  wr_x;
  logic [H-1:0]  wr_y;
  logic [DW-1:0] wr_rgb;
  logic          clear_req;
  logic          frame_start;
  logic          busy;
  logic          scan_valid;
  logic          scan_ready;
  logic [W-1:0]  scan_x;
  logic [H-1:0]  scan_y;
  logic [DW-1:0] scan_rgb;
  logic          scan_last;
  logic [7:0]    frame_count;
  state_t        debug_state;

  frame_buffer_scanout #(.width(W), .height(H), .color_bits(CB)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_rgb      (wr_rgb),
    .clear_req   (clear_req),
    .frame_start (frame_start),
    .busy        (busy),
    .scan_valid  (scan_valid),
    .scan_ready  (scan_ready),
    .scan_x      (scan_x),
    .scan_y      (scan_y),
    .scan_rgb    (scan_rgb),
    .scan_last   (scan_last),
    .frame_count (frame_count),
    .debug_state (debug_state)
  );

  // reference model and scoreboard
  rgb_t          model_mem [NPIX];
  logic [SBW-1:0] exp_q[$];
  logic [DW-1:0] cap_rgb [NPIX];
  logic          cap_last [NPIX];
  logic [7:0]    exp_fc;
  int            n_cmp;
  int            n_bad;

  typedef struct {
    logic [W-1:0]  x;
    logic [H-1:0]  y;
    logic [DW-1:0] rgb;
    int            exp_idx;
    bit            exp_last;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks: entered and left just after a falling edge
  task automatic write_px(input logic [W-1:0] x, input logic [H-1:0] y, input logic [DW-1:0] rgb);
    int n;
    n = 0;
    wr_x = x; wr_y = y; wr_rgb = rgb; wr_valid = 1'b1;
    while (!wr_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("wr_ready_wait", 64'(wr_ready), 64'(1));
    if (wr_ready) begin
      @(negedge clk);
      model_mem[{y, x}] = rgb;
    end
    wr_valid = 1'b0;
  endtask

  task automatic random_writes(input int count);
    for (int i = 0; i < count; i++) begin
      write_px(W'($urandom_range(0, (1 << W) - 1)), H'($urandom_range(0, (1 << H) - 1)),
               DW'($urandom));
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for 3 cycles at pixel 10
  task automatic run_scan(input int mode, input bit check_pix, input bit with_clear, input bit late_wr);
    int got, cycles, stall_left;
    bit stalled_once, have_snap;
    logic [SBW-1:0] snap, obs, exp;
    logic [ADDR-1:0] a;
    got = 0; cycles = 0; stall_left = 0; stalled_once = 0; have_snap = 0; snap = '0;
    exp_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      a = ADDR'(i);
      exp_q.push_back({a, model_mem[i], (i == NPIX - 1)});
    end
    frame_start = 1'b1; clear_req = with_clear;
    @(negedge clk);
    frame_start = 1'b0; clear_req = 1'b0; wr_valid = late_wr;
    check("scan_valid_after_start", 64'(scan_valid), 64'(1));
    while (got < NPIX && cycles < 4 * NPIX + 50) begin
      obs = {scan_y, scan_x, scan_rgb, scan_last};
      if (have_snap) begin
        check("hold_stable", 64'(obs), 64'(snap));
        have_snap = 0;
      end
      if (mode == 2 && got == 10 && !stalled_once) begin
        stall_left = 3;
        stalled_once = 1;
      end
      case (mode)
        0:       scan_ready = 1'b1;
        1:       scan_ready = ($urandom_range(0, 3) != 0);
        default: scan_ready = (stall_left == 0);
      endcase
      if (stall_left > 0) stall_left--;
      if (wr_valid) check("wr_ready_during_scan", 64'(wr_ready), 64'(0));
      if (scan_valid && scan_ready) begin
        exp = exp_q.pop_front();
        if (check_pix) check("scan_pixel", 64'(obs), 64'(exp));
        cap_rgb[got] = scan_rgb;
        cap_last[got] = scan_last;
        got++;
      end else if (scan_valid) begin
        snap = obs;
        have_snap = 1;
      end
      @(negedge clk);
      cycles++;
    end
    scan_ready = 1'b0;
    check("scan_complete", 64'(got), 64'(NPIX));
    if (mode == 0) check("no_bubbles", 64'(cycles), 64'(NPIX));
    exp_fc = exp_fc + 8'd1;
    check("valid_low_after_last", 64'(scan_valid), 64'(0));
    check("busy_low_after_last", 64'(busy), 64'(0));
    check("frame_count", 64'(frame_count), 64'(exp_fc));
  endtask

`ifdef FRAME_BUFFER_CLEAR_EN
  task automatic wait_clear(input string name);
    int n;
    bit any_valid;
    n = 0; any_valid = 0;
    while (busy && n < 1000) begin
      if (scan_valid) any_valid = 1;
      n++;
      @(negedge clk);
    end
    check(name, 64'(n), 64'(NPIX));
    repeat (10) begin
      if (scan_valid) any_valid = 1;
      @(negedge clk);
    end
    check("no_valid_around_clear", 64'(any_valid), 64'(0));
    for (int i = 0; i < NPIX; i++) model_mem[i] = '0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0; exp_fc = 8'd0;
    reset = 1'b1; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_rgb = '0;
    clear_req = 1'b0; frame_start = 1'b0; scan_ready = 1'b0;

    vecs[0] = '{x: 4'd3,  y: 3'd2, rgb: 24'hFF0000, exp_idx: 35,  exp_last: 1'b0};
    vecs[1] = '{x: 4'd15, y: 3'd7, rgb: 24'h00FF00, exp_idx: 127, exp_last: 1'b1};
    vecs[2] = '{x: 4'd0,  y: 3'd0, rgb: 24'h123456, exp_idx: 0,   exp_last: 1'b0};
    vecs[3] = '{x: 4'd15, y: 3'd0, rgb: 24'hABCDEF, exp_idx: 15,  exp_last: 1'b0};
    vecs[4] = '{x: 4'd0,  y: 3'd7, rgb: 24'h0F0F0F, exp_idx: 112, exp_last: 1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_scan_valid", 64'(scan_valid), 64'(0));
    check("rst_scan_last", 64'(scan_last), 64'(0));
    check("rst_scan_x", 64'(scan_x), 64'(0));
    check("rst_scan_y", 64'(scan_y), 64'(0));
    check("rst_scan_rgb", 64'(scan_rgb), 64'(0));
    check("rst_frame_count", 64'(frame_count), 64'(0));
    check("rst_wr_ready", 64'(wr_ready), 64'(1));
    check("rst_state", 64'(debug_state), 64'(ST_IDLE));

    // define every pixel so the whole frame is predictable
    for (int i = 0; i < NPIX; i++) begin
      write_px(W'(i % (1 << W)), H'(i / (1 << W)), DW'($urandom));
    end

    // table-driven pixel placement
    foreach (vecs[i]) write_px(vecs[i].x, vecs[i].y, vecs[i].rgb);
    run_scan(0, 1'b1, 1'b0, 1'b0);
    foreach (vecs[i]) begin
      check("table_rgb", 64'(cap_rgb[vecs[i].exp_idx]), 64'(vecs[i].rgb));
      check("table_last", 64'(cap_last[vecs[i].exp_idx]), 64'(vecs[i].exp_last));
    end

    // backpressure at pixel 10, then random traffic
    run_scan(2, 1'b1, 1'b0, 1'b0);
    repeat (3) begin
      random_writes(12);
      run_scan(1, 1'b1, 1'b0, 1'b0);
    end

    // write in the same cycle as frame_start must be visible to that scan
    wr_x = 4'd0; wr_y = 3'd0; wr_rgb = DW'($urandom); wr_valid = 1'b1;
    model_mem[0] = wr_rgb;
    run_scan(0, 1'b1, 1'b0, 1'b0);
    wr_x = 4'd5; wr_y = 3'd1; wr_rgb = DW'($urandom); wr_valid = 1'b1;
    model_mem[21] = wr_rgb;
    run_scan(1, 1'b1, 1'b0, 1'b0);

    // write offered during a scan waits until the scan is over
    wr_x = 4'd7; wr_y = 3'd3; wr_rgb = DW'($urandom); wr_valid = 1'b0;
    run_scan(0, 1'b1, 1'b0, 1'b1);
    check("wr_ready_after_scan", 64'(wr_ready), 64'(1));
    @(negedge clk);
    wr_valid = 1'b0;
    model_mem[55] = wr_rgb;
    run_scan(1, 1'b1, 1'b0, 1'b0);

`ifdef FRAME_BUFFER_CLEAR_EN
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    wait_clear("clear_busy_cycles");
    run_scan(0, 1'b1, 1'b0, 1'b0);
    random_writes(8);
    clear_req = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    clear_req = 1'b0; frame_start = 1'b0;
    wait_clear("clear_wins_busy_cycles");
    run_scan(0, 1'b1, 1'b0, 1'b0);
`else
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    check("clear_ignored_busy", 64'(busy), 64'(0));
    check("clear_ignored_wr_ready", 64'(wr_ready), 64'(1));
    check("clear_ignored_valid", 64'(scan_valid), 64'(0));
    run_scan(0, 1'b1, 1'b1, 1'b0);
`endif

    // reset in the middle of a scan
    scan_ready = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (50) @(negedge clk);
    check("pixel50_x", 64'(scan_x), 64'(2));
    check("pixel50_y", 64'(scan_y), 64'(3));
    reset = 1'b1;
    @(negedge clk);
    check("abort_scan_valid", 64'(scan_valid), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_frame_count", 64'(frame_count), 64'(0));
    check("abort_wr_ready", 64'(wr_ready), 64'(1));
    check("abort_state", 64'(debug_state), 64'(ST_IDLE));
    reset = 1'b0; scan_ready = 1'b0; exp_fc = 8'd0;

    // 256 scans wrap the frame counter back to zero
    repeat (256) run_scan(0, 1'b0, 1'b0, 1'b0);
    check("frame_count_wrapped", 64'(frame_count), 64'(0));
    run_scan(1, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
